mux_arb_nx1: RTL and testbench

MUX_ARB_NX1 -- requirements
Module: mux_arb_nx1

---
 rtl/mux_pkg.sv | 15 +
 rtl/mux_nx1.sv | 35 +++
 rtl/mux_arb_nx1.sv | 128 ++++++++++++
 tb/tb_mux_arb_nx1.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared types and helpers for the N:1 arbitrated output register.
package mux_pkg;

  // Output register occupancy
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Select width for an n-way choice (at least one bit)
  function automatic int unsigned sel_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_nx1.sv
// Parametric N:1 combinational mux built as a balanced tree of 2:1 stages.
// Leaves beyond N are tied to zero so the tree is always a full power of two.
module mux_nx1 #(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 32,
  parameter int unsigned SEL_W = 2
) (
  input  logic [N*W-1:0]   in_data,
  input  logic [SEL_W-1:0] sel,
  output logic [W-1:0]     out_data
);

  localparam int unsigned P = 1 << SEL_W;

  genvar gs, gj;
  for (gs = 0; gs <= SEL_W; gs++) begin : g_lvl
    localparam int unsigned CNT = P >> gs;
    logic [CNT-1:0][W-1:0] v;
    for (gj = 0; gj < CNT; gj++) begin : g_ent
      if (gs == 0) begin : g_leaf
        if (gj < N) begin : g_real
          assign v[gj] = in_data[gj*W +: W];
        end else begin : g_pad
          assign v[gj] = '0;
        end
      end else begin : g_mux
        // Level gs folds adjacent pairs using select bit gs-1
        assign v[gj] = sel[gs-1] ? g_lvl[gs-1].v[2*gj+1] : g_lvl[gs-1].v[2*gj];
      end
    end
  end

  assign out_data = g_lvl[SEL_W].v[0];

endmodule

// File: rtl/mux_arb_nx1.sv
// N-channel arbiter feeding a single registered output word with
// valid/ready handshakes on both sides and 1 word/cycle throughput.
// Optional macro MUX_ARB_RR_EN selects round-robin arbitration;
// otherwise the lowest valid channel index wins.
module mux_arb_nx1
  import mux_pkg::*;
#(
  parameter  int unsigned N     = 4,
  parameter  int unsigned W     = 32,
  localparam int unsigned SEL_W = sel_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in_valid,
  input  logic [N*W-1:0]   in_data,
  output logic [N-1:0]     in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_chan,
  input  logic             out_ready
);

  state_t             state_q, state_d;
  logic [W-1:0]       data_q, data_d;
  logic [SEL_W-1:0]   chan_q, chan_d;
  logic               can_load;
  logic               grant_any;
  logic [SEL_W-1:0]   grant_idx;
  logic [SEL_W-1:0]   search_base;
  logic [W-1:0]       mux_data;
  int unsigned        idx;

`ifdef MUX_ARB_RR_EN
  logic [SEL_W-1:0]   ptr_q, ptr_d;

  assign search_base = ptr_q;

  // Pointer moves just past the granted channel, holds otherwise
  always_comb begin
    ptr_d = ptr_q;
    if (grant_any) begin
      ptr_d = (32'(grant_idx) == N - 1) ? '0 : grant_idx + SEL_W'(1);
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign search_base = '0;
`endif

  assign can_load = (state_q == EMPTY) || out_ready;

  // Pick the first valid channel at or above search_base, wrapping modulo N
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(search_base) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!grant_any && can_load && !rst && in_valid[SEL_W'(idx)]) begin
        grant_any = 1'b1;
        grant_idx = SEL_W'(idx);
      end
    end
  end

  // One-hot accept strobe for the granted channel
  always_comb begin
    in_ready = '0;
    if (grant_any) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  mux_nx1 #(
    .N     (N),
    .W     (W),
    .SEL_W (SEL_W)
  ) u_mux (
    .in_data  (in_data),
    .sel      (grant_idx),
    .out_data (mux_data)
  );

  // Output register next state: load on grant, drain when consumed, else hold
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    chan_d  = chan_q;
    if (can_load) begin
      if (grant_any) begin
        state_d = FULL;
        data_d  = mux_data;
        chan_d  = grant_idx;
      end else begin
        state_d = EMPTY;
      end
    end
  end

  // Output register; reset discards any held word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_chan  = chan_q;

endmodule

// File: tb/tb_mux_arb_nx1.sv
// Directed bench for mux_arb_nx1 at N=4, W=8; expectations follow MUX_ARB_RR_EN.
module tb_mux_arb_nx1;

`ifdef MUX_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_ready;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  iv;
    logic [31:0] d;
    logic        r;
    logic [3:0]  eir;
    logic        eov;
    logic [7:0]  eod;
    logic [1:0]  eoc;
  } vec_t;

  vec_t vecs [10];

  mux_arb_nx1 #(.N(4), .W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] d, input logic [1:0] ch);
    logic [31:0] t;
    t = d;
    return t[ch*8 +: 8];
  endfunction

  // One clock: drive at negedge, check in_ready before the edge, outputs after it
  task automatic cyc(input string tag, input logic [3:0] v, input logic [31:0] d,
                     input logic r, input logic [3:0] eir, input logic eov,
                     input logic [7:0] eod, input logic [1:0] eoc);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(eir));
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(eov));
    if (eov) begin
      chk({tag, ".out_data"}, 32'(out_data), 32'(eod));
      chk({tag, ".out_chan"}, 32'(out_chan), 32'(eoc));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid  = '0;
    out_ready = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0]  ec;
    logic [1:0]  m;
    logic [31:0] d;
    int          words;

    //          iv       data          r     eir      eov   eod    eoc
    vecs[0] = '{4'b0100, 32'h003C0000, 1'b1, 4'b0100, 1'b1, 8'h3C, 2'd2};
    vecs[1] = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd2};
    vecs[2] = '{4'b0001, 32'h000000AA, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd2};
    vecs[3] = '{4'b0001, 32'h000000AA, 1'b1, 4'b0001, 1'b1, 8'hAA, 2'd0};
    vecs[4] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
    vecs[5] = '{4'b1000, 32'h5A000000, 1'b0, 4'b1000, 1'b1, 8'h5A, 2'd3};
    vecs[6] = '{4'b0010, 32'h0000C300, 1'b1, 4'b0010, 1'b1, 8'hC3, 2'd1};
    vecs[7] = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b1, 8'hC3, 2'd1};
    vecs[8] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
    vecs[9] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};

    // Reset held with all channels offering: nothing may be granted
    rst       = 1'b1;
    in_valid  = 4'hF;
    in_data   = 32'h77665544;
    out_ready = 1'b1;
    #2;
    chk("por.out_valid", 32'(out_valid), 32'd0);
    chk("por.out_chan",  32'(out_chan),  32'd0);
    chk("por.out_data",  32'(out_data),  32'd0);
    chk("por.in_ready",  32'(in_ready),  32'd0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = '0;

    for (int i = 0; i < 10; i++) begin
      cyc($sformatf("vec%0d", i), vecs[i].iv, vecs[i].d, vecs[i].r,
          vecs[i].eir, vecs[i].eov, vecs[i].eod, vecs[i].eoc);
    end

    // Backpressure: held word survives stalls, new word loads on release
    do_reset();
    cyc("bp.load", 4'b0001, 32'h00000011, 1'b0, 4'b0001, 1'b1, 8'h11, 2'd0);
    for (int i = 0; i < 3; i++) begin
      cyc($sformatf("bp.stall%0d", i), 4'hF, 32'h77665544, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd0);
    end
    cyc("bp.release", 4'hF, 32'h77665544, 1'b1, RR ? 4'b0010 : 4'b0001, 1'b1,
        RR ? 8'h55 : 8'h44, RR ? 2'd1 : 2'd0);

    // All channels valid: rotation with wrap, or fixed priority
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ec = RR ? 2'(i) : 2'd0;
      cyc($sformatf("arb%0d", i), 4'hF, 32'h77665544, 1'b1, 4'b0001 << ec, 1'b1,
          byte_of(32'h77665544, ec), ec);
    end
    cyc("arb.drop0", 4'b1110, 32'h77665544, 1'b1, 4'b0010, 1'b1, 8'h55, 2'd1);

    // Reset mid-transfer between edges, then first grant from pointer 0
    do_reset();
    cyc("rst.load", 4'b0001, 32'h000000A5, 1'b0, 4'b0001, 1'b1, 8'hA5, 2'd0);
    @(negedge clk);
    in_valid  = 4'hF;
    in_data   = 32'h77665544;
    out_ready = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_chan",  32'(out_chan),  32'd0);
    chk("rst.out_data",  32'(out_data),  32'd0);
    chk("rst.in_ready",  32'(in_ready),  32'd0);
    #1;
    rst = 1'b0;
    cyc("rst.first", 4'hF, 32'h77665544, 1'b1, 4'b0001, 1'b1, 8'h44, 2'd0);

    // Throughput: 100 words on 100 consecutive cycles, then drain
    do_reset();
    words = 0;
    m = 2'd0;
    for (int i = 0; i < 100; i++) begin
      d  = $urandom;
      ec = RR ? m : 2'd0;
      cyc($sformatf("tp%0d", i), 4'hF, d, 1'b1, 4'b0001 << ec, 1'b1, byte_of(d, ec), ec);
      if (out_valid) words++;
      m = m + 2'd1;
    end
    chk("tp.words", 32'(words), 32'd100);
    cyc("drain", 4'b0000, 32'h0, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
